// File: rtl/ball_pkg.sv
// Shared constants, types and helpers for the ball sprite position path.
// zone_of() is also used by the renderer so both agree on depth zones.
package ball_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned Z_MAX        = 999;
  localparam int unsigned COORD_W      = 16;
  localparam int unsigned ZONE_W       = 4;
  localparam int unsigned N_ZONES      = 10;
  localparam int unsigned ZONE_STEP    = 100;
  localparam int unsigned SIZE_W       = 10;

  // Sprite edge length per depth zone, nearest first.
  localparam logic [SIZE_W-1:0] STAGE [N_ZONES] = '{
    10'd69, 10'd59, 10'd51, 10'd43, 10'd37, 10'd31, 10'd25, 10'd21, 10'd17, 10'd15
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ZONE  = 2'd2,
    ST_APPLY = 2'd3
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } pos_t;

  // Depth zone of z after clamping to Z_MAX: one zone per ZONE_STEP of depth.
  function automatic logic [ZONE_W-1:0] zone_of(input logic [COORD_W-1:0] z);
    logic [COORD_W-1:0] zc;
    logic [ZONE_W-1:0]  zn;
    zc = (z > COORD_W'(Z_MAX)) ? COORD_W'(Z_MAX) : z;
    zn = '0;
    for (int unsigned i = 1; i < N_ZONES; i++) begin
      if (zc >= COORD_W'(i * ZONE_STEP)) zn = ZONE_W'(i);
    end
    return zn;
  endfunction

  // Out-of-range zones fall back to the smallest sprite.
  function automatic logic [SIZE_W-1:0] stage_of(input logic [ZONE_W-1:0] zone);
    if (zone < ZONE_W'(N_ZONES)) return STAGE[zone];
    return STAGE[N_ZONES-1];
  endfunction

endpackage

// File: rtl/ball_pos_sched_if.sv
// Game-logic write channel, scan-line input and committed renderer position.
interface ball_pos_sched_if;
  import ball_pkg::*;

  logic [COORD_W-1:0] pixel_y;
  logic               wr_valid;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [COORD_W-1:0] wr_z;
  logic               wr_ready;
  logic [COORD_W-1:0] x_loc;
  logic [COORD_W-1:0] y_loc;
  logic [COORD_W-1:0] z_loc;
  logic [ZONE_W-1:0]  zone;
  logic               commit;
  logic [COORD_W-1:0] frame_cnt;

  modport master (
    output pixel_y, wr_valid, wr_x, wr_y, wr_z,
    input  wr_ready, x_loc, y_loc, z_loc, zone, commit, frame_cnt
  );

  modport slave (
    input  pixel_y, wr_valid, wr_x, wr_y, wr_z,
    output wr_ready, x_loc, y_loc, z_loc, zone, commit, frame_cnt
  );

endinterface

// File: rtl/ball_clamp.sv
// Combinational clamp keeping a zone-sized sprite fully on screen.
module ball_clamp
  import ball_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  pos_t              pos_i,
  input  logic [ZONE_W-1:0] zone_i,
  output pos_t              pos_c_o
);

  logic [SIZE_W-1:0]  sz;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_max;

  always_comb begin
    sz      = stage_of(zone_i);
    x_max   = COORD_W'(H_ACTIVE - 1) - COORD_W'(sz);
    y_max   = COORD_W'(V_ACTIVE - 1) - COORD_W'(sz);
    pos_c_o = pos_i;
    if (pos_i.x > x_max)            pos_c_o.x = x_max;
    if (pos_i.y > y_max)            pos_c_o.y = y_max;
    if (pos_i.z > COORD_W'(Z_MAX))  pos_c_o.z = COORD_W'(Z_MAX);
  end

endmodule

// File: rtl/ball_pos_sched.sv
// Holds one pending ball position and commits it to the renderer only at the
// start of vertical blanking, with depth zone and on-screen clamping applied.
module ball_pos_sched
  import ball_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  ball_pos_sched_if.slave  bus_if
);

  state_e             state_q, state_d;
  pos_t               pend_q, pend_d;
  logic [ZONE_W-1:0]  zone_p_q, zone_p_d;
  pos_t               out_q, out_d;
  logic [ZONE_W-1:0]  zone_q, zone_d;
  logic               commit_q, commit_d;
  logic               wr_ready_q, wr_ready_d;
  logic [COORD_W-1:0] pixel_y_q;
  logic [COORD_W-1:0] frame_cnt_q, frame_cnt_d;
  pos_t               clamped_c;
  logic               vb_start_c;
  logic               hs_c;

  // Rising edge of "on the first blanking line"; skipping that line never fires.
  assign vb_start_c = (bus_if.pixel_y == COORD_W'(V_ACTIVE)) &&
                      (pixel_y_q != COORD_W'(V_ACTIVE));
  assign hs_c       = bus_if.wr_valid && wr_ready_q;

  ball_clamp #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_clamp (
    .pos_i   (pend_q),
    .zone_i  (zone_p_q),
    .pos_c_o (clamped_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (hs_c) state_d = ST_PEND;
      ST_PEND:  if (vb_start_c) state_d = ST_ZONE;
      ST_ZONE:  state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    pend_d     = pend_q;
    zone_p_d   = zone_p_q;
    out_d      = out_q;
    zone_d     = zone_q;
    commit_d   = 1'b0;
    wr_ready_d = (state_d == ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          pend_d.x = bus_if.wr_x;
          pend_d.y = bus_if.wr_y;
          pend_d.z = bus_if.wr_z;
        end
      end
      ST_ZONE:  zone_p_d = zone_of(pend_q.z);
      ST_APPLY: begin
        out_d    = clamped_c;
        zone_d   = zone_p_q;
        commit_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign frame_cnt_d = vb_start_c ? frame_cnt_q + COORD_W'(1) : frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      zone_p_q    <= '0;
      out_q       <= '0;
      zone_q      <= '0;
      commit_q    <= 1'b0;
      wr_ready_q  <= 1'b1;
      pixel_y_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      zone_p_q    <= zone_p_d;
      out_q       <= out_d;
      zone_q      <= zone_d;
      commit_q    <= commit_d;
      wr_ready_q  <= wr_ready_d;
      pixel_y_q   <= bus_if.pixel_y;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus_if.wr_ready  = wr_ready_q;
  assign bus_if.x_loc     = out_q.x;
  assign bus_if.y_loc     = out_q.y;
  assign bus_if.z_loc     = out_q.z;
  assign bus_if.zone      = zone_q;
  assign bus_if.commit    = commit_q;
  assign bus_if.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ball_pos_sched.sv
// Scenario-driven bench for ball_pos_sched with a frame-level reference model.
module tb_ball_pos_sched;
  import ball_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ball_pos_sched_if bus();

  ball_pos_sched #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_x, exp_y, exp_z, exp_zone, exp_frames;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sprite_size(input int zn);
    case (zn)
      0: return 69;  1: return 59;  2: return 51;  3: return 43;  4: return 37;
      5: return 31;  6: return 25;  7: return 21;  8: return 17;  default: return 15;
    endcase
  endfunction

  // Expected committed outputs for a requested position.
  task automatic model_commit(input int x, input int y, input int z);
    int zc, sz;
    zc       = (z > 999) ? 999 : z;
    exp_zone = zc / 100;
    sz       = sprite_size(exp_zone);
    exp_x    = (x > 639 - sz) ? 639 - sz : x;
    exp_y    = (y > 479 - sz) ? 479 - sz : y;
    exp_z    = zc;
  endtask

  task automatic write_update(input int x, input int y, input int z);
    bus.wr_valid = 1'b1;
    bus.wr_x = 16'(x);
    bus.wr_y = 16'(y);
    bus.wr_z = 16'(z);
    step();
    bus.wr_valid = 1'b0;
  endtask

  // Drives 479 -> 480 and records commit in the three cycles after vb_start.
  task automatic vblank(output logic [2:0] c);
    bus.pixel_y = 16'd479;
    step();
    bus.pixel_y = 16'd480;
    step();
    c[0] = bus.commit;
    step();
    c[1] = bus.commit;
    step();
    c[2] = bus.commit;
    bus.pixel_y = 16'd0;
    exp_frames++;
  endtask

  function automatic logic [51:0] outs_now();
    return {bus.x_loc, bus.y_loc, bus.z_loc, bus.zone};
  endfunction

  function automatic logic [51:0] outs_exp();
    return {16'(exp_x), 16'(exp_y), 16'(exp_z), 4'(exp_zone)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pixel_y = '0; bus.wr_valid = 1'b0;
    bus.wr_x = '0; bus.wr_y = '0; bus.wr_z = '0;
    exp_x = 0; exp_y = 0; exp_z = 0; exp_zone = 0; exp_frames = 0;
    #12;
    n_checks++;
    if ({bus.wr_ready, bus.commit, bus.frame_cnt, outs_now()} !== {1'b1, 1'b0, 16'd0, 52'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h",
               {bus.wr_ready, bus.commit, bus.frame_cnt, outs_now()}, {1'b1, 1'b0, 16'd0, 52'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_commit(input string nm, input int x, input int y, input int z);
    logic [2:0] c;
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_ready_before: got %b required 1", nm, bus.wr_ready);
    end
    write_update(x, y, z);
    model_commit(x, y, z);
    vblank(c);
    n_checks++;
    if (c !== 3'b100) begin
      n_fail++; $display("FAIL %s_commit_timing: got %b required 100", nm, c);
    end
    n_checks++;
    if (outs_now() !== outs_exp()) begin
      n_fail++; $display("FAIL %s_outputs: got %h required %h", nm, outs_now(), outs_exp());
    end
    n_checks++;
    if ({bus.wr_ready, bus.frame_cnt} !== {1'b1, 16'(exp_frames)}) begin
      n_fail++; $display("FAIL %s_ready_frames: got %h required %h", nm,
                         {bus.wr_ready, bus.frame_cnt}, {1'b1, 16'(exp_frames)});
    end
  endtask

  task automatic test_zone_edges();
    for (int k = 1; k <= 10; k++) begin
      test_commit("zone_lo", 65535, 65535, k * 100 - 1);
      if (k < 10) test_commit("zone_hi", 65535, 65535, k * 100);
    end
  endtask

  task automatic test_midframe();
    logic [2:0] c;
    logic [51:0] held;
    int bad;
    held = outs_exp();
    bus.pixel_y = 16'd100;
    step();
    write_update(200, 100, 420);
    model_commit(200, 100, 420);
    n_checks++;
    if (bus.wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL midframe_ready_low: got %b required 0", bus.wr_ready);
    end
    bus.wr_valid = 1'b1;
    bus.wr_x = 16'd5; bus.wr_y = 16'd5; bus.wr_z = 16'd5;
    bad = 0;
    for (int py = 101; py <= 479; py++) begin
      bus.pixel_y = 16'(py);
      step();
      if (bus.wr_ready !== 1'b0 || bus.commit !== 1'b0 || outs_now() !== held) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL midframe_hold: got %0d bad cycles required 0", bad);
    end
    bus.wr_valid = 1'b0;
    vblank(c);
    n_checks++;
    if ({c, outs_now()} !== {3'b100, outs_exp()}) begin
      n_fail++; $display("FAIL midframe_commit: got %h required %h", {c, outs_now()}, {3'b100, outs_exp()});
    end
  endtask

  task automatic test_hold_480();
    int commits;
    write_update(300, 200, 777);
    model_commit(300, 200, 777);
    bus.pixel_y = 16'd479;
    step();
    bus.pixel_y = 16'd480;
    commits = 0;
    repeat (800) begin
      step();
      if (bus.commit === 1'b1) commits++;
    end
    exp_frames++;
    n_checks++;
    if (commits != 1) begin
      n_fail++; $display("FAIL hold480_commits: got %0d required 1", commits);
    end
    n_checks++;
    if ({bus.frame_cnt, outs_now()} !== {16'(exp_frames), outs_exp()}) begin
      n_fail++; $display("FAIL hold480_state: got %h required %h",
                         {bus.frame_cnt, outs_now()}, {16'(exp_frames), outs_exp()});
    end
    bus.pixel_y = 16'd0;
    step();
  endtask

  task automatic test_skip_line();
    logic [2:0] c;
    int commits;
    logic [51:0] held;
    held = outs_exp();
    write_update(10, 20, 30);
    bus.pixel_y = 16'd300;
    step();
    bus.pixel_y = 16'd481;
    commits = 0;
    repeat (5) begin
      step();
      if (bus.commit === 1'b1) commits++;
    end
    n_checks++;
    if ({commits[3:0], bus.wr_ready, bus.frame_cnt, outs_now()} !== {4'd0, 1'b0, 16'(exp_frames), held}) begin
      n_fail++; $display("FAIL skip_no_commit: got %h required %h",
                         {commits[3:0], bus.wr_ready, bus.frame_cnt, outs_now()},
                         {4'd0, 1'b0, 16'(exp_frames), held});
    end
    bus.pixel_y = 16'd0;
    step();
    model_commit(10, 20, 30);
    vblank(c);
    n_checks++;
    if ({c, outs_now()} !== {3'b100, outs_exp()}) begin
      n_fail++; $display("FAIL skip_later_commit: got %h required %h", {c, outs_now()}, {3'b100, outs_exp()});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] c;
    write_update(40, 60, 150);
    vblank(c);
    write_update(500, 400, 880);
    n_checks++;
    if (bus.wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accepted: got wr_ready %b required 0", bus.wr_ready);
    end
    repeat (4) step();
    model_commit(500, 400, 880);
    vblank(c);
    n_checks++;
    if ({c, outs_now()} !== {3'b100, outs_exp()}) begin
      n_fail++; $display("FAIL b2b_commit: got %h required %h", {c, outs_now()}, {3'b100, outs_exp()});
    end
  endtask

  task automatic test_random();
    int x, y, z;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.pixel_y = 16'($urandom_range(0, 478));
        step();
      end
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 700));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 520));
      z = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1000, 65535)) : int'($urandom_range(0, 1100));
      test_commit("random", x, y, z);
    end
  endtask

  task automatic test_reset_in_zone();
    logic [2:0] c;
    write_update(123, 321, 555);
    bus.pixel_y = 16'd479;
    step();
    bus.pixel_y = 16'd480;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.wr_ready, bus.commit, bus.frame_cnt, outs_now()} !== {1'b1, 1'b0, 16'd0, 52'd0}) begin
      n_fail++; $display("FAIL zone_reset_async: got %h required %h",
                         {bus.wr_ready, bus.commit, bus.frame_cnt, outs_now()}, {1'b1, 1'b0, 16'd0, 52'd0});
    end
    bus.pixel_y = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_frames = 0;
    vblank(c);
    n_checks++;
    if ({c, bus.wr_ready, bus.frame_cnt, outs_now()} !== {3'b000, 1'b1, 16'd1, 52'd0}) begin
      n_fail++; $display("FAIL zone_reset_discard: got %h required %h",
                         {c, bus.wr_ready, bus.frame_cnt, outs_now()}, {3'b000, 1'b1, 16'd1, 52'd0});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_commit("basic", 100, 50, 250);
    test_commit("clamp_xy", 630, 470, 50);
    test_commit("zmax", 700, 300, 1500);
    test_zone_edges();
    test_midframe();
    test_hold_480();
    test_skip_line();
    test_back_to_back();
    test_random();
    test_reset_in_zone();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
